// File: rtl/control_pkg.sv
// Shared definitions for the interrupt sequencer: FSM states, source codes
// and the default opcode injected for every interrupt/reset event.
package control_pkg;

    typedef enum logic [1:0] {
        RST_PEND = 2'd0,
        IDLE     = 2'd1,
        ARMED    = 2'd2,
        RUNNING  = 2'd3
    } seq_state_t;

    localparam int SRC_RESET    = 0;
    localparam int SRC_NMI      = 1;
    localparam int SRC_IRQ_BASE = 2;

    localparam logic [7:0] BRK_OPCODE_DEFAULT = 8'h00;

endpackage

// File: rtl/irq_priority_encoder.sv
// Fixed-priority arbiter: latched NMI first, then IRQ0 (highest) .. IRQ(N-1).
module irq_priority_encoder
    import control_pkg::*;
#(
    parameter int NUM_IRQ = 4,
    parameter int SRC_W   = $clog2(NUM_IRQ + 2)
) (
    input  logic               i_nmi_pending,
    input  logic [NUM_IRQ-1:0] i_irq_eff,
    output logic               o_valid,
    output logic [SRC_W-1:0]   o_source
);

    always_comb begin
        o_valid  = i_nmi_pending | (|i_irq_eff);
        o_source = SRC_W'(SRC_RESET);
        if (i_nmi_pending) begin
            o_source = SRC_W'(SRC_NMI);
        end else begin
            // Descending scan so the lowest-numbered active line wins.
            for (int i = NUM_IRQ - 1; i >= 0; i--) begin
                if (i_irq_eff[i]) begin
                    o_source = SRC_W'(SRC_IRQ_BASE + i);
                end
            end
        end
    end

endmodule

// File: rtl/interrupt_sequencer.sv
// Reset/NMI/IRQ sequencer: injects the BRK opcode at the next opcode fetch,
// reports the serviced source and tracks the running handler sequence.
module interrupt_sequencer
    import control_pkg::*;
#(
    parameter int                  NUM_IRQ    = 4,
    parameter int                  OP_WIDTH   = 8,
    parameter logic [OP_WIDTH-1:0] BRK_OPCODE = OP_WIDTH'(BRK_OPCODE_DEFAULT),
    parameter int                  SRC_W      = $clog2(NUM_IRQ + 2)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enableFFs,
    input  logic                nonMaskableInterrupt,
    input  logic [NUM_IRQ-1:0]  interruptRequest,
    input  logic [NUM_IRQ-1:0]  irqMask,
    input  logic                processStatusRegIFlag,
    input  logic                loadNextInstruction,
    input  logic                serviceDone,
    input  logic [OP_WIDTH-1:0] externalDB,
    output logic [OP_WIDTH-1:0] nextInstruction,
    output logic                instructionRegReadEnable,
    output logic                enableIFlag,
    output logic [SRC_W-1:0]    sourceSel,
    output logic                resetRunning,
    output logic                nmiRunning,
    output logic                irqRunning,
    output logic                nmiPending
);

    seq_state_t         r_state;
    logic               r_nmi_prev;
    logic               r_nmi_pend;
    logic [SRC_W-1:0]   r_src;
    logic               r_reset_run;
    logic               r_nmi_run;
    logic               r_irq_run;

    logic [NUM_IRQ-1:0] w_irq_eff;
    logic               w_nmi_edge;
    logic               w_arb_valid;
    logic [SRC_W-1:0]   w_arb_src;
    logic               w_inject_rst;
    logic               w_inject_arm;
    logic               w_inject_nmi;

    assign w_irq_eff  = interruptRequest & ~irqMask & {NUM_IRQ{~processStatusRegIFlag}};
    assign w_nmi_edge = nonMaskableInterrupt & ~r_nmi_prev;

    irq_priority_encoder #(
        .NUM_IRQ (NUM_IRQ),
        .SRC_W   (SRC_W)
    ) u_prio (
        .i_nmi_pending (r_nmi_pend),
        .i_irq_eff     (w_irq_eff),
        .o_valid       (w_arb_valid),
        .o_source      (w_arb_src)
    );

    // Injection only happens on enabled cycles so a stalled fetch is never doubled.
    assign w_inject_rst = !rst && enableFFs && (r_state == RST_PEND);
    assign w_inject_arm = !rst && enableFFs && (r_state == ARMED) && w_arb_valid
                          && loadNextInstruction;
    assign w_inject_nmi = w_inject_arm && (w_arb_src == SRC_W'(SRC_NMI));

    always_comb begin
        nextInstruction          = externalDB;
        instructionRegReadEnable = loadNextInstruction;
        enableIFlag              = 1'b0;
        sourceSel                = r_src;
        resetRunning             = r_reset_run;
        nmiRunning               = r_nmi_run;
        irqRunning               = r_irq_run;
        nmiPending               = r_nmi_pend;
        if (rst) begin
            instructionRegReadEnable = 1'b0;
            sourceSel                = SRC_W'(SRC_RESET);
            resetRunning             = 1'b0;
            nmiRunning               = 1'b0;
            irqRunning               = 1'b0;
            nmiPending               = 1'b0;
        end else if (r_state == RST_PEND) begin
            instructionRegReadEnable = w_inject_rst;
            sourceSel                = SRC_W'(SRC_RESET);
            if (w_inject_rst) begin
                nextInstruction = BRK_OPCODE;
                enableIFlag     = 1'b1;
            end
        end else begin
            if ((r_state == ARMED) && w_arb_valid) begin
                sourceSel = w_arb_src;
            end
            if (w_inject_arm) begin
                nextInstruction = BRK_OPCODE;
                enableIFlag     = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= RST_PEND;
            r_nmi_prev  <= 1'b0;
            r_nmi_pend  <= 1'b0;
            r_src       <= SRC_W'(SRC_RESET);
            r_reset_run <= 1'b0;
            r_nmi_run   <= 1'b0;
            r_irq_run   <= 1'b0;
        end else if (enableFFs) begin
            r_nmi_prev <= nonMaskableInterrupt;
            // A fresh edge in the injection cycle must survive the clear.
            if (w_nmi_edge) begin
                r_nmi_pend <= 1'b1;
            end else if (w_inject_nmi) begin
                r_nmi_pend <= 1'b0;
            end

            case (r_state)
                RST_PEND: begin
                    r_state     <= RUNNING;
                    r_src       <= SRC_W'(SRC_RESET);
                    r_reset_run <= 1'b1;
                end
                IDLE: begin
                    if (w_arb_valid) begin
                        r_state <= ARMED;
                        r_src   <= w_arb_src;
                    end
                end
                ARMED: begin
                    if (!w_arb_valid) begin
                        r_state <= IDLE;
                    end else begin
                        r_src <= w_arb_src;
                        if (loadNextInstruction) begin
                            r_state   <= RUNNING;
                            r_nmi_run <= (w_arb_src == SRC_W'(SRC_NMI));
                            r_irq_run <= (w_arb_src != SRC_W'(SRC_NMI));
                        end
                    end
                end
                RUNNING: begin
                    if (serviceDone) begin
                        r_state     <= IDLE;
                        r_reset_run <= 1'b0;
                        r_nmi_run   <= 1'b0;
                        r_irq_run   <= 1'b0;
                    end
                end
                default: r_state <= RST_PEND;
            endcase
        end
    end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed bench for interrupt_sequencer with a queue-based expected-value scoreboard.
module tb_interrupt_sequencer;

    logic       clk;
    logic       rst;
    logic       en;
    logic       nmi;
    logic [3:0] irq;
    logic [3:0] mask;
    logic       iflag;
    logic       load;
    logic       done;
    logic [7:0] db;

    logic [7:0] ni;
    logic       ire;
    logic       eif;
    logic [2:0] src;
    logic       rr;
    logic       nr;
    logic       ir;
    logic       np;

    typedef struct packed {
        logic [7:0] ni;
        logic       ire;
        logic       eif;
        logic [2:0] src;
        logic       rr;
        logic       nr;
        logic       ir;
        logic       np;
    } obs_t;

    obs_t sb_q[$];
    int   n_cmp;
    int   n_err;

    interrupt_sequencer dut (
        .clk                      (clk),
        .rst                      (rst),
        .enableFFs                (en),
        .nonMaskableInterrupt     (nmi),
        .interruptRequest         (irq),
        .irqMask                  (mask),
        .processStatusRegIFlag    (iflag),
        .loadNextInstruction      (load),
        .serviceDone              (done),
        .externalDB               (db),
        .nextInstruction          (ni),
        .instructionRegReadEnable (ire),
        .enableIFlag              (eif),
        .sourceSel                (src),
        .resetRunning             (rr),
        .nmiRunning               (nr),
        .irqRunning               (ir),
        .nmiPending               (np)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs were just driven on the falling edge; sample 1 ns later, well clear of posedge.
    task automatic step(input string tag, input logic [7:0] e_ni, input logic e_ire,
                        input logic e_eif, input logic [2:0] e_src, input logic e_rr,
                        input logic e_nr, input logic e_ir, input logic e_np);
        obs_t e;
        obs_t o;
        e = '{e_ni, e_ire, e_eif, e_src, e_rr, e_nr, e_ir, e_np};
        sb_q.push_back(e);
        #1;
        o = '{ni, ire, eif, src, rr, nr, ir, np};
        e = sb_q.pop_front();
        n_cmp++;
        assert (o === e) else begin
            n_err++;
            $error("FAIL %s observed={ni=%h ire=%b eif=%b src=%0d rr=%b nr=%b ir=%b np=%b} expected={ni=%h ire=%b eif=%b src=%0d rr=%b nr=%b ir=%b np=%b}",
                   tag, o.ni, o.ire, o.eif, o.src, o.rr, o.nr, o.ir, o.np,
                   e.ni, e.ire, e.eif, e.src, e.rr, e.nr, e.ir, e.np);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1; en = 1'b1; nmi = 1'b0; irq = 4'h0; mask = 4'h0;
        iflag = 1'b0; load = 1'b0; done = 1'b0; db = 8'hA9;

        // Reset state, including a fetch request that must be suppressed
        @(negedge clk); step("rst_hold",       8'hA9, 0, 0, 3'd0, 0, 0, 0, 0);
        @(negedge clk); load = 1'b1;
                        step("rst_load_block", 8'hA9, 0, 0, 3'd0, 0, 0, 0, 0);

        // 1: reset release -> forced BRK, then resetRunning until serviceDone
        @(negedge clk); load = 1'b0; rst = 1'b0;
                        step("rst_inject",     8'h00, 1, 1, 3'd0, 0, 0, 0, 0);
        @(negedge clk); step("rst_running",    8'hA9, 0, 0, 3'd0, 1, 0, 0, 0);
        @(negedge clk); done = 1'b1;
                        step("rst_done_cyc",   8'hA9, 0, 0, 3'd0, 1, 0, 0, 0);
        @(negedge clk); done = 1'b0;
                        step("rst_idle",       8'hA9, 0, 0, 3'd0, 0, 0, 0, 0);

        // 2: IRQ1 and IRQ2 requested, IRQ1 wins
        @(negedge clk); irq = 4'b0110;
                        step("irq_idle",       8'hA9, 0, 0, 3'd0, 0, 0, 0, 0);
        @(negedge clk); step("irq_armed",      8'hA9, 0, 0, 3'd3, 0, 0, 0, 0);
        @(negedge clk); load = 1'b1;
                        step("irq_inject",     8'h00, 1, 1, 3'd3, 0, 0, 0, 0);
        @(negedge clk); load = 1'b0; irq = 4'h0;
                        step("irq_running",    8'hA9, 0, 0, 3'd3, 0, 0, 1, 0);
        @(negedge clk); done = 1'b1;
                        step("irq_done_cyc",   8'hA9, 0, 0, 3'd3, 0, 0, 1, 0);
        @(negedge clk); done = 1'b0;
                        step("irq_back_idle",  8'hA9, 0, 0, 3'd3, 0, 0, 0, 0);

        // 2b: I flag blocks all IRQs; the fetch passes externalDB through
        @(negedge clk); iflag = 1'b1; irq = 4'b0110;
                        step("iflag_idle",     8'hA9, 0, 0, 3'd3, 0, 0, 0, 0);
        @(negedge clk); step("iflag_stay",     8'hA9, 0, 0, 3'd3, 0, 0, 0, 0);
        @(negedge clk); load = 1'b1;
                        step("iflag_fetch",    8'hA9, 1, 0, 3'd3, 0, 0, 0, 0);
        @(negedge clk); load = 1'b0; iflag = 1'b0; irq = 4'h0;
                        step("iflag_clear",    8'hA9, 0, 0, 3'd3, 0, 0, 0, 0);

        // 3: IRQ2 armed, NMI edge upgrades the source before the fetch
        @(negedge clk); irq = 4'b0100;
                        step("upg_idle",       8'hA9, 0, 0, 3'd3, 0, 0, 0, 0);
        @(negedge clk); step("upg_armed_irq2", 8'hA9, 0, 0, 3'd4, 0, 0, 0, 0);
        @(negedge clk); nmi = 1'b1;
                        step("upg_edge_cyc",   8'hA9, 0, 0, 3'd4, 0, 0, 0, 0);
        @(negedge clk); step("upg_nmi_won",    8'hA9, 0, 0, 3'd1, 0, 0, 0, 1);
        @(negedge clk); load = 1'b1;
                        step("upg_inject",     8'h00, 1, 1, 3'd1, 0, 0, 0, 1);
        @(negedge clk); load = 1'b0; irq = 4'h0; nmi = 1'b0;
                        step("upg_running",    8'hA9, 0, 0, 3'd1, 0, 1, 0, 0);
        @(negedge clk); done = 1'b1;
                        step("upg_done_cyc",   8'hA9, 0, 0, 3'd1, 0, 1, 0, 0);
        @(negedge clk); done = 1'b0;
                        step("upg_idle_end",   8'hA9, 0, 0, 3'd1, 0, 0, 0, 0);

        // 4: IRQ0 drops while armed -> no phantom BRK
        @(negedge clk); irq = 4'b0001;
                        step("drop_idle",      8'hA9, 0, 0, 3'd1, 0, 0, 0, 0);
        @(negedge clk); step("drop_armed",     8'hA9, 0, 0, 3'd2, 0, 0, 0, 0);
        @(negedge clk); irq = 4'h0;
                        step("drop_released",  8'hA9, 0, 0, 3'd2, 0, 0, 0, 0);
        @(negedge clk); db = 8'hEA; load = 1'b1;
                        step("drop_passthru",  8'hEA, 1, 0, 3'd2, 0, 0, 0, 0);
        @(negedge clk); db = 8'hA9; load = 1'b0;

        // 5: three NMI edges while running merge into one NMI BRK
                        irq = 4'b0001;
                        step("merge_idle",     8'hA9, 0, 0, 3'd2, 0, 0, 0, 0);
        @(negedge clk); step("merge_armed",    8'hA9, 0, 0, 3'd2, 0, 0, 0, 0);
        @(negedge clk); load = 1'b1;
                        step("merge_inject0",  8'h00, 1, 1, 3'd2, 0, 0, 0, 0);
        @(negedge clk); load = 1'b0; irq = 4'h0; nmi = 1'b1;
                        step("merge_e1",       8'hA9, 0, 0, 3'd2, 0, 0, 1, 0);
        @(negedge clk); nmi = 1'b0;
                        step("merge_l1",       8'hA9, 0, 0, 3'd2, 0, 0, 1, 1);
        @(negedge clk); nmi = 1'b1;
                        step("merge_e2",       8'hA9, 0, 0, 3'd2, 0, 0, 1, 1);
        @(negedge clk); nmi = 1'b0;
                        step("merge_l2",       8'hA9, 0, 0, 3'd2, 0, 0, 1, 1);
        @(negedge clk); nmi = 1'b1;
                        step("merge_e3",       8'hA9, 0, 0, 3'd2, 0, 0, 1, 1);
        @(negedge clk); nmi = 1'b0; done = 1'b1;
                        step("merge_done_cyc", 8'hA9, 0, 0, 3'd2, 0, 0, 1, 1);
        @(negedge clk); done = 1'b0;
                        step("merge_idle2",    8'hA9, 0, 0, 3'd2, 0, 0, 0, 1);
        @(negedge clk); step("merge_armed2",   8'hA9, 0, 0, 3'd1, 0, 0, 0, 1);
        @(negedge clk); load = 1'b1;
                        step("merge_inject1",  8'h00, 1, 1, 3'd1, 0, 0, 0, 1);
        @(negedge clk); load = 1'b0;
                        step("merge_nmi_run",  8'hA9, 0, 0, 3'd1, 0, 1, 0, 0);
        @(negedge clk); done = 1'b1;
                        step("merge_done2",    8'hA9, 0, 0, 3'd1, 0, 1, 0, 0);
        @(negedge clk); done = 1'b0;
                        step("merge_idle3",    8'hA9, 0, 0, 3'd1, 0, 0, 0, 0);
        @(negedge clk); load = 1'b1;
                        step("merge_no_extra", 8'hA9, 1, 0, 3'd1, 0, 0, 0, 0);
        @(negedge clk); load = 1'b0;

        // 6: reset while armed, released with enableFFs low
                        irq = 4'b0001;
                        step("rarm_idle",      8'hA9, 0, 0, 3'd1, 0, 0, 0, 0);
        @(negedge clk); step("rarm_armed",     8'hA9, 0, 0, 3'd2, 0, 0, 0, 0);
        @(negedge clk); rst = 1'b1;
                        step("rarm_rst",       8'hA9, 0, 0, 3'd0, 0, 0, 0, 0);
        @(negedge clk); rst = 1'b0; en = 1'b0;
                        step("rarm_hold0",     8'hA9, 0, 0, 3'd0, 0, 0, 0, 0);
        @(negedge clk); step("rarm_hold1",     8'hA9, 0, 0, 3'd0, 0, 0, 0, 0);
        @(negedge clk); en = 1'b1;
                        step("rarm_inject",    8'h00, 1, 1, 3'd0, 0, 0, 0, 0);
        @(negedge clk); step("rarm_running",   8'hA9, 0, 0, 3'd0, 1, 0, 0, 0);
        @(negedge clk); en = 1'b0; done = 1'b1;
                        step("rarm_done_gate", 8'hA9, 0, 0, 3'd0, 1, 0, 0, 0);
        @(negedge clk); en = 1'b1; done = 1'b0;
                        step("rarm_still_run", 8'hA9, 0, 0, 3'd0, 1, 0, 0, 0);
        @(negedge clk); done = 1'b1;
                        step("rarm_done_cyc",  8'hA9, 0, 0, 3'd0, 1, 0, 0, 0);
        @(negedge clk); done = 1'b0;
                        step("rarm_idle",      8'hA9, 0, 0, 3'd0, 0, 0, 0, 0);
        @(negedge clk); irq = 4'h0;
                        step("rarm_drop",      8'hA9, 0, 0, 3'd2, 0, 0, 0, 0);
        @(negedge clk); step("rarm_final",     8'hA9, 0, 0, 3'd2, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/interrupt_sequencer.md
Name: interrupt_sequencer

Overview:
- Parametrised successor to the single-IRQ/NMI opcode injector in the control-logic path.
- Arbitrates reset, one edge-triggered NMI and NUM_IRQ maskable level IRQ sources.
- Forces the BRK opcode onto the instruction-register input at the next opcode fetch, and raises the I-flag set request.
- Drives a source-select code to the vector-address logic and holds per-source "running" status until the handler sequence signals completion.

Parameters:
- NUM_IRQ, 4: number of maskable IRQ lines, 1..8.
- OP_WIDTH, 8: opcode width.
- BRK_OPCODE, 8'h00: opcode injected for every event.
- SRC_W, $clog2(NUM_IRQ+2): width of the source code.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- enableFFs  in  1  global advance enable. When low, all state and edge detectors hold.
- nonMaskableInterrupt  in  1  NMI request, rising-edge sensitive.
- interruptRequest  in  NUM_IRQ  IRQ requests, level sensitive.
- irqMask  in  NUM_IRQ  per-source mask, 1 = masked.
- processStatusRegIFlag  in  1  PSR I flag. When 1, all IRQs are blocked.
- loadNextInstruction  in  1  decoder requests an opcode fetch this cycle.
- serviceDone  in  1  one-cycle pulse when the vector fetch of the BRK sequence completes.
- externalDB  in  OP_WIDTH  external data bus.
- nextInstruction  out  OP_WIDTH  instruction-register input.
- instructionRegReadEnable  out  1  instruction-register load enable.
- enableIFlag  out  1  request to set the PSR I flag.
- sourceSel  out  SRC_W  active source: 0 = reset, 1 = NMI, 2+i = IRQ i.
- resetRunning, nmiRunning, irqRunning  out  1  sequence-in-progress flags.
- nmiPending  out  1  latched NMI not yet injected.

Behaviour:
- States: RST_PEND, IDLE, ARMED, RUNNING.
- While rst = 1:
  - State goes to RST_PEND and the NMI latch and edge register clear.
  - Outputs: sourceSel = 0, running flags 0, nmiPending 0, instructionRegReadEnable 0, enableIFlag 0, nextInstruction = externalDB.
- RST_PEND (first cycle with rst = 0 and enableFFs = 1):
  - Combinational outputs: instructionRegReadEnable = 1, nextInstruction = BRK_OPCODE, enableIFlag = 1, sourceSel = 0.
  - Next state RUNNING with resetRunning = 1.
  - The load fires regardless of loadNextInstruction.
- All states except RST_PEND:
  - Default outputs: nextInstruction = externalDB, instructionRegReadEnable = loadNextInstruction.
  - In RST_PEND the forced load and BRK opcode above take precedence.
- NMI edge detect:
  - nmiPending sets on a 0→1 transition of nonMaskableInterrupt sampled across consecutive enabled cycles.
  - Multiple edges before injection merge into one pending NMI.
  - nmiPending clears on the cycle the NMI is injected.
  - An edge arriving in that same cycle re-sets it; set wins over clear.
- Effective IRQ: irqEff = interruptRequest & ~irqMask & {NUM_IRQ{~processStatusRegIFlag}}.
- Priority: reset > NMI > irqEff[0] > ... > irqEff[NUM_IRQ-1].
- IDLE:
  - If nmiPending or |irqEff, go to ARMED and capture the winning source into sourceSel.
- ARMED:
  - Source is re-arbitrated every cycle, so an NMI upgrades a pending IRQ.
  - If nothing is requesting any more (IRQ dropped or got masked), return to IDLE. No phantom BRK is injected.
  - On loadNextInstruction = 1: nextInstruction = BRK_OPCODE, enableIFlag = 1. The winning source is frozen.
  - Next state RUNNING; the matching running flag is set.
- RUNNING:
  - No injection. IRQs are ignored; NMI edges still latch.
  - On serviceDone, clear running flags and go to IDLE.
  - From IDLE, a latched NMI re-arms on the following cycle.
- Latency: from an NMI edge to the BRK load = 2 cycles + wait for loadNextInstruction.
- enableFFs = 0: state, NMI latch, edge register and running flags all hold.
  - Combinational outputs still reflect the current state.
- Reset mid-sequence (any state) aborts the sequence. The next enabled cycle after release is RST_PEND.

Decomposition:
- Shared package control_pkg holds:
  - the state enum (RST_PEND, IDLE, ARMED, RUNNING);
  - source code constants SRC_RESET = 0, SRC_NMI = 1, SRC_IRQ_BASE = 2;
  - the default BRK opcode.
- One sub-module, irq_priority_encoder:
  - parametrised NUM_IRQ;
  - combinational;
  - takes nmiPending and irqEff, returns the valid bit and the source code.

Test Plan:
1. Release rst with enableFFs = 1 → next cycle: instructionRegReadEnable = 1, nextInstruction = 8'h00, enableIFlag = 1, sourceSel = 0. Then resetRunning = 1 until a serviceDone pulse.
2. IDLE, interruptRequest = 4'b0110, irqMask = 0, I = 0, loadNextInstruction pulse → BRK injected, sourceSel = 3 (IRQ1), irqRunning = 1. With I = 1 instead → no injection; opcode = externalDB (e.g. 8'hA9).
3. IRQ2 armed, then NMI edge before loadNextInstruction → sourceSel becomes 1, nmiRunning = 1, nmiPending clears at injection.
4. IRQ0 asserted then dropped before loadNextInstruction → state returns to IDLE; externalDB 8'hEA is passed through on the fetch.
5. Three NMI edges during RUNNING → after serviceDone, exactly one further NMI BRK is injected.
6. rst asserted while in ARMED with enableFFs = 0 on release → outputs hold reset values until enableFFs = 1, then the case-1 response.
